nibble_add_seq: RTL

Multi-precision adder sequencer that computes a (4·NIBBLES)-bit sum by driving one shared `full_add_4` 4-bit ripple adder, one nibble per clock, least significant nibble first. A registered carry links the nibbles. The block sits between a requesting controller (start/done handshake) and the adder datapath. It trades latency for area when operands are wider than the adder.

---
 rtl/nibble_add_seq_pkg.sv | 15 +
 rtl/full_add_4.sv | 30 +++
 rtl/nibble_add_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/nibble_add_seq_pkg.sv
// nibble_add_seq_pkg
//   Shared definitions for the nibble-serial adder sequencer:
//   - NIB_W   : width of one adder slice (one nibble)
//   - state_t : sequencer FSM encoding (IDLE=0, RUN=1, DONE=2)
package nibble_add_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_add_4.sv
// full_add_4
//   Combinational 4-bit ripple-carry adder.
//   Ports:
//     a, b  in  [3:0]  addends
//     cin   in         carry into bit 0
//     sum   out [3:0]  a + b + cin (low 4 bits)
//     cout  out        carry out of bit 3
module full_add_4
  import nibble_add_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit; carry ripples from bit 0 upward.
  for (genvar gi = 0; gi < NIB_W; gi++) begin : g_bit
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_add_seq.sv
// nibble_add_seq
//   Multi-precision adder: computes a + b + cin over 4*NIBBLES bits by
//   pushing one nibble per clock through a single full_add_4, LS nibble
//   first, with the inter-nibble carry held in a register.
//   Ports:
//     clk    in          rising-edge clock
//     rst_n  in          asynchronous active-low reset
//     start  in          request, sampled only while ready=1
//     a, b   in  [W-1:0] operands, captured on the accepted start
//     cin    in          carry into the LS nibble, captured with a/b
//     ready  out         high in IDLE
//     busy   out         high in RUN
//     done   out         one-cycle pulse in DONE; sum/cout valid from here
//     sum    out [W-1:0] result register (holds until the next result)
//     cout   out         carry out of the MS nibble
module nibble_add_seq
  import nibble_add_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                     cin,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                     cout
);

  localparam int W    = NIB_W * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES) + 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

  state_t          state_reg, state_next;
  logic [W-1:0]    a_sh_reg,  a_sh_next;
  logic [W-1:0]    b_sh_reg,  b_sh_next;
  logic            carry_reg, carry_next;
  logic [IDXW-1:0] idx_reg,   idx_next;
  logic [W-1:0]    acc_reg,   acc_next;
  logic [W-1:0]    sum_reg,   sum_next;
  logic            cout_reg,  cout_next;

  logic [NIB_W-1:0] add_sum;
  logic             add_cout;
  logic [W-1:0]     acc_shifted;

  full_add_4 u_add (
    .a    (a_sh_reg[NIB_W-1:0]),
    .b    (b_sh_reg[NIB_W-1:0]),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // New nibble enters at the top and everything moves down one nibble, so
  // after NIBBLES steps the LS result nibble sits at bit 0. Written as a
  // shift/or so the expression also holds for NIBBLES=1 (no upper part).
  assign acc_shifted = (acc_reg >> NIB_W) | (W'(add_sum) << (W - NIB_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_sh_reg  <= a_sh_next;
      b_sh_reg  <= b_sh_next;
      carry_reg <= carry_next;
      idx_reg   <= idx_next;
      acc_reg   <= acc_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_sh_next  = a_sh_reg;
    b_sh_next  = b_sh_reg;
    carry_next = carry_reg;
    idx_next   = idx_reg;
    acc_next   = acc_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          a_sh_next  = a;
          b_sh_next  = b;
          carry_next = cin;
          idx_next   = '0;
          acc_next   = '0;
        end
      end

      ST_RUN: begin
        a_sh_next  = a_sh_reg >> NIB_W;
        b_sh_next  = b_sh_reg >> NIB_W;
        carry_next = add_cout;
        acc_next   = acc_shifted;
        idx_next   = idx_reg + IDXW'(1);
        // Last nibble: publish the result on this same edge so it is
        // already valid in the DONE cycle.
        if (idx_reg == IDX_LAST) begin
          state_next = ST_DONE;
          sum_next   = acc_shifted;
          cout_next  = add_cout;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Status is decoded from the state register only.
  assign ready = (state_reg == ST_IDLE);
  assign busy  = (state_reg == ST_RUN);
  assign done  = (state_reg == ST_DONE);
  assign sum   = sum_reg;
  assign cout  = cout_reg;

endmodule
